temp_sample_scheduler: RTL and testbench

Sequences periodic reads of the on-board temperature sensor through the I2C master's start/done handshake and turns each raw 8-bit Celsius reading into conditioned results. It outputs the latest sample, running min/max, an exponential moving average, an over-temperature alarm with hysteresis, and fault status. It sits between the I2C master and its consumers: the 7-segment controller, the Fahrenheit converter and the LEDs.

---
 rtl/temp_sample_scheduler.sv | 134 +++++++++++++
 tb/tb_temp_sample_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sample_scheduler.sv
// Periodic I2C temperature sampler: min/max, EMA, hysteresis alarm and fault status.
// Define TEMP_SCHED_ALARM_EN to build the over-temperature alarm; otherwise alarm is tied low.
module temp_sample_scheduler #(
   parameter int         PERIOD_CYCLES  = 100_000_000,
   parameter int         TIMEOUT_CYCLES = 1_000_000,
   parameter int         AVG_SHIFT      = 2,
   parameter logic [7:0] ALARM_HI       = 8'd30,
   parameter logic [7:0] ALARM_LO       = 8'd28
) (
   input  logic        clk_100MHz,
   input  logic        rst_n,
   output logic        i2c_start,
   input  logic        i2c_done,
   input  logic        i2c_err,
   input  logic [7:0]  i2c_data,
   output logic [7:0]  temp_c,
   output logic [7:0]  temp_min,
   output logic [7:0]  temp_max,
   output logic [7:0]  temp_avg,
   output logic        sample_valid,
   output logic [15:0] sample_cnt,
   output logic [7:0]  err_cnt,
   output logic        fault,
   output logic        alarm
);
   localparam int PW = $clog2(PERIOD_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = 8 + AVG_SHIFT;

   typedef enum logic [2:0] {IDLE, START, WAIT, UPDATE, ERROR} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   period_cnt;
   logic            tick;
   logic [TW-1:0]   tout_cnt;
   logic            timeout;
   logic [7:0]      samp_p0;
   logic [AW-1:0]   acc, acc_nxt;
   logic            have_sample;

   function automatic logic [AW-1:0] ema_step(input logic [AW-1:0] a, input logic [7:0] s,
                                              input logic first);
      if (first) return AW'(s) << AVG_SHIFT;
      return a - (a >> AVG_SHIFT) + AW'(s);
   endfunction

   function automatic logic [7:0] avg_of(input logic [AW-1:0] a);
      logic [AW-1:0] t;
      t = a >> AVG_SHIFT;
      return t[7:0];
   endfunction

   // Down-counter reloads from zero, so the tick lands in the first cycle after reset.
   assign tick    = (period_cnt == '0);
   assign timeout = (tout_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign acc_nxt = ema_step(acc, samp_p0, !have_sample);

   always_ff @(posedge clk_100MHz) begin
      if (!rst_n)    period_cnt <= '0;
      else if (tick) period_cnt <= PW'(PERIOD_CYCLES - 1);
      else           period_cnt <= period_cnt - 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tick) state_nxt = START;
         START:   state_nxt = WAIT;
         WAIT: begin
            if (i2c_err)       state_nxt = ERROR;
            else if (i2c_done) state_nxt = UPDATE;
            else if (timeout)  state_nxt = ERROR;
         end
         UPDATE:  state_nxt = IDLE;
         ERROR:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_100MHz) begin
      if (!rst_n) begin
         state        <= IDLE;
         i2c_start    <= 1'b0;
         sample_valid <= 1'b0;
         tout_cnt     <= '0;
         samp_p0      <= '0;
         acc          <= '0;
         have_sample  <= 1'b0;
         temp_c       <= '0;
         temp_min     <= 8'hFF;
         temp_max     <= '0;
         temp_avg     <= '0;
         sample_cnt   <= '0;
         err_cnt      <= '0;
         fault        <= 1'b0;
      end else begin
         state        <= state_nxt;
         i2c_start    <= (state == START);
         sample_valid <= (state == UPDATE);
         if (state == START)     tout_cnt <= '0;
         else if (state == WAIT) tout_cnt <= tout_cnt + 1'b1;
         if (state == WAIT && i2c_done) samp_p0 <= i2c_data;
         // Commit stage: all result registers move together with sample_valid.
         if (state == UPDATE) begin
            temp_c      <= samp_p0;
            acc         <= acc_nxt;
            temp_avg    <= avg_of(acc_nxt);
            have_sample <= 1'b1;
            if (samp_p0 < temp_min) temp_min <= samp_p0;
            if (samp_p0 > temp_max) temp_max <= samp_p0;
            sample_cnt  <= sample_cnt + 1'b1;
            fault       <= 1'b0;
         end
         if (state == ERROR) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
            fault <= 1'b1;
         end
      end
   end

`ifdef TEMP_SCHED_ALARM_EN
   always_ff @(posedge clk_100MHz) begin
      if (!rst_n) begin
         alarm <= 1'b0;
      end else if (state == UPDATE) begin
         if (samp_p0 >= ALARM_HI)      alarm <= 1'b1;
         else if (samp_p0 <= ALARM_LO) alarm <= 1'b0;
      end
   end
`else
   assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_temp_sample_scheduler.sv
// Bench for temp_sample_scheduler: vector table, corner sequences and randomized traffic vs a model.
module tb_temp_sample_scheduler;
   localparam int         PER = 100;
   localparam int         TO  = 20;
   localparam int         SH  = 2;
   localparam logic [7:0] HI  = 8'd30;
   localparam logic [7:0] LO  = 8'd28;
`ifdef TEMP_SCHED_ALARM_EN
   localparam bit ALARM_ON = 1'b1;
`else
   localparam bit ALARM_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        i2c_start, i2c_done = 1'b0, i2c_err = 1'b0;
   logic [7:0]  i2c_data = '0;
   logic [7:0]  temp_c, temp_min, temp_max, temp_avg, err_cnt;
   logic        sample_valid, fault, alarm;
   logic [15:0] sample_cnt;

   logic        start2, done2 = 1'b0, err2 = 1'b0;
   logic [7:0]  data2 = '0;
   logic [7:0]  c2, min2, max2, avg2, errc2;
   logic        valid2, fault2, alarm2;
   logic [15:0] cnt2;

   temp_sample_scheduler #(.PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(TO), .AVG_SHIFT(SH),
                           .ALARM_HI(HI), .ALARM_LO(LO)) dut (
      .clk_100MHz(clk), .rst_n(rst_n), .i2c_start(i2c_start), .i2c_done(i2c_done),
      .i2c_err(i2c_err), .i2c_data(i2c_data), .temp_c(temp_c), .temp_min(temp_min),
      .temp_max(temp_max), .temp_avg(temp_avg), .sample_valid(sample_valid),
      .sample_cnt(sample_cnt), .err_cnt(err_cnt), .fault(fault), .alarm(alarm));

   // Long-timeout instance for the overrun case.
   temp_sample_scheduler #(.PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(1000), .AVG_SHIFT(SH),
                           .ALARM_HI(HI), .ALARM_LO(LO)) dut_ovr (
      .clk_100MHz(clk), .rst_n(rst_n), .i2c_start(start2), .i2c_done(done2),
      .i2c_err(err2), .i2c_data(data2), .temp_c(c2), .temp_min(min2),
      .temp_max(max2), .temp_avg(avg2), .sample_valid(valid2),
      .sample_cnt(cnt2), .err_cnt(errc2), .fault(fault2), .alarm(alarm2));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model, straight from the sampling rules.
   int m_c, m_min, m_max, m_acc, m_cnt, m_err;
   bit m_fault, m_alarm, m_first;

   task automatic model_reset();
      m_c = 0; m_min = 255; m_max = 0; m_acc = 0; m_cnt = 0; m_err = 0;
      m_fault = 0; m_alarm = 0; m_first = 1;
   endtask

   task automatic model_good(input int s);
      m_c = s;
      if (s < m_min) m_min = s;
      if (s > m_max) m_max = s;
      if (m_first) m_acc = s * (2 ** SH);
      else         m_acc = m_acc - m_acc / (2 ** SH) + s;
      m_first = 0;
      m_cnt = (m_cnt + 1) % 65536;
      m_fault = 0;
      if (ALARM_ON && s >= HI)      m_alarm = 1;
      else if (ALARM_ON && s <= LO) m_alarm = 0;
   endtask

   task automatic model_err();
      if (m_err < 255) m_err++;
      m_fault = 1;
   endtask

   task automatic check_outputs(input string tag, input bit v);
      chk({tag, ".valid"}, sample_valid, v);
      chk({tag, ".temp_c"}, temp_c, m_c);
      chk({tag, ".min"}, temp_min, m_min);
      chk({tag, ".max"}, temp_max, m_max);
      chk({tag, ".avg"}, temp_avg, m_acc / (2 ** SH));
      chk({tag, ".cnt"}, sample_cnt, m_cnt);
      chk({tag, ".err_cnt"}, err_cnt, m_err);
      chk({tag, ".fault"}, fault, m_fault);
      chk({tag, ".alarm"}, alarm, m_alarm);
   endtask

   int prev_start = -1;

   task automatic wait_start(output int n);
      bit ok;
      ok = 0;
      n = 0;
      while (n < 250 && !ok) begin
         @(negedge clk);
         n++;
         if (i2c_start === 1'b1) ok = 1;
      end
      chk("start_seen", ok, 1);
      if (prev_start >= 0) chk("start_spacing", cyc - prev_start, PER);
      prev_start = cyc;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; i2c_done = 0; i2c_err = 0; done2 = 0; err2 = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      prev_start = -1;
   endtask

   // kind: 0 good, 1 error, 2 done+error together, 3 no answer (timeout)
   task automatic run_txn(input int kind, input logic [7:0] d, input int dly);
      if (kind == 3) begin
         repeat (TO) @(negedge clk);
         chk("to.fault_early", fault, m_fault);
         @(negedge clk);
         model_err();
         check_outputs("timeout", 0);
      end else begin
         repeat (dly) @(negedge clk);
         i2c_data = d;
         i2c_done = (kind != 1);
         i2c_err  = (kind != 0);
         @(negedge clk);
         i2c_done = 0; i2c_err = 0;
         chk("valid_early", sample_valid, 0);
         @(negedge clk);
         if (kind == 0) model_good(d);
         else           model_err();
         check_outputs(kind == 0 ? "good" : "err", kind == 0);
         @(negedge clk);
         chk("valid_pulse_end", sample_valid, 0);
      end
   endtask

   typedef struct {
      bit          rst;
      logic [7:0]  d;
      logic [7:0]  c, mn, mx, avg;
      logic [15:0] cnt;
      bit          al;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation stuck at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, s2, kind, r;
      bit ok;
      tbl[0] = '{1, 20, 20, 20, 20, 20, 1, 0};
      tbl[1] = '{0, 40, 40, 20, 40, 25, 2, 1};
      tbl[2] = '{0, 40, 40, 20, 40, 28, 3, 1};
      tbl[3] = '{1, 29, 29, 29, 29, 29, 1, 0};
      tbl[4] = '{0, 30, 30, 29, 30, 29, 2, 1};
      tbl[5] = '{0, 29, 29, 29, 30, 29, 3, 1};
      tbl[6] = '{0, 28, 28, 28, 30, 29, 4, 0};
      tbl[7] = '{0, 31, 31, 28, 31, 29, 5, 1};

      // Reset state and first start timing
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs("reset", 0);
      chk("reset.start", i2c_start, 0);
      rst_n = 1'b1;
      wait_start(n);
      chk("first_start_lat", n, 2);
      run_txn(0, 25, 10);
      chk("seq.avg25", temp_avg, 25);
      chk("seq.cnt1", sample_cnt, 1);
      for (int i = 0; i < 2; i++) begin
         wait_start(n);
         run_txn(0, 25, 10);
      end

      // Table of EMA/min/max and alarm hysteresis sequences
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].rst) do_reset();
         wait_start(n);
         repeat (10) @(negedge clk);
         i2c_data = tbl[i].d; i2c_done = 1;
         @(negedge clk);
         i2c_done = 0;
         chk("tbl.valid_early", sample_valid, 0);
         @(negedge clk);
         chk("tbl.valid", sample_valid, 1);
         chk("tbl.temp_c", temp_c, tbl[i].c);
         chk("tbl.min", temp_min, tbl[i].mn);
         chk("tbl.max", temp_max, tbl[i].mx);
         chk("tbl.avg", temp_avg, tbl[i].avg);
         chk("tbl.cnt", sample_cnt, tbl[i].cnt);
         chk("tbl.alarm", alarm, ALARM_ON ? tbl[i].al : 1'b0);
      end

      // Timeout, recovery, error priority, then randomized traffic
      do_reset();
      wait_start(n);
      run_txn(0, 45, 3);
      wait_start(n);
      run_txn(3, 0, 0);
      wait_start(n);
      run_txn(0, 50, 4);
      wait_start(n);
      run_txn(2, 99, 6);
      wait_start(n);
      run_txn(1, 0, 2);
      for (int i = 0; i < 20; i++) begin
         wait_start(n);
         r = $urandom_range(0, 9);
         kind = (r == 0) ? 1 : (r == 1) ? 3 : (r == 2) ? 2 : 0;
         run_txn(kind, 8'($urandom_range(0, 255)), $urandom_range(0, 15));
      end

      // Overrun: slow answer drops the tick in between
      do_reset();
      n = 0; ok = 0;
      while (n < 250 && !ok) begin
         @(negedge clk); n++;
         if (start2 === 1'b1) ok = 1;
      end
      chk("ovr.start_seen", ok, 1);
      s2 = cyc;
      repeat (150) @(negedge clk);
      data2 = 8'd33; done2 = 1;
      @(negedge clk);
      done2 = 0;
      @(negedge clk);
      chk("ovr.valid", valid2, 1);
      chk("ovr.temp_c", c2, 33);
      chk("ovr.fault", fault2, 0);
      n = 0; ok = 0;
      while (n < 250 && !ok) begin
         @(negedge clk); n++;
         if (start2 === 1'b1) ok = 1;
      end
      chk("ovr.next_start", cyc - s2, 200);

      // Reset in the middle of WAIT, stale done afterwards
      do_reset();
      wait_start(n);
      run_txn(0, 60, 5);
      wait_start(n);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      i2c_data = 8'd77; i2c_done = 1;
      model_reset();
      @(negedge clk);
      i2c_done = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_wait.valid", sample_valid, 0);
      end
      check_outputs("rst_wait", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
